// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared sizing and types for the 4096x16 sample-buffer SRAM model.
// Imported by the SRAM model and by the k-means engine that owns it.
//   ADDR_W : address width (12)
//   DATA_W : word width (16); a sample point is packed as x[15:8], y[7:0]
//   DEPTH  : number of words, always 2**ADDR_W
//   addr_t : word address type
//   word_t : data word type
// ---------------------------------------------------------------------------
package sram_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/shab90_4096x16_sram_if.sv
// ---------------------------------------------------------------------------
// shab90_4096x16_sram_if
// Request-side pins of the single-port SRAM.
//   A   : word address, sampled on rising clk
//   DI  : write data, sampled on rising clk
//   WEB : write enable, active-low (0 = write, 1 = read)
//   OE  : output enable, active-high (gates DO combinationally)
//   CS  : chip select, active-high
// Protocol: there is no valid/ready handshake. Every rising clk edge with
// CS=1 and the SRAM out of reset is exactly one access; CS=0 is idle and the
// other request pins are ignored. Read data appears on DO one edge after the
// address is presented.
// Modports: master drives the request pins, slave (the SRAM) samples them.
// ---------------------------------------------------------------------------
interface shab90_4096x16_sram_if;
  import sram_pkg::*;

  addr_t A;
  word_t DI;
  logic  WEB;
  logic  OE;
  logic  CS;

  modport master (output A, output DI, output WEB, output OE, output CS);
  modport slave  (input  A, input  DI, input  WEB, input  OE, input  CS);

endinterface

// File: rtl/sram_array.sv
// ---------------------------------------------------------------------------
// sram_array
// Storage array with a synchronous write port and a registered read port.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high clear of the read register only
//   we     : write mem[addr] <= wdata on the edge
//   rd_en  : load read register from mem[addr] on the edge
//   wt_en  : load read register from wdata on the edge (write-through)
//   addr   : word address
//   wdata  : write data
//   rd_q   : read register
// The array itself has no reset: stored words survive rst.
// ---------------------------------------------------------------------------
module sram_array
  import sram_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  logic  rd_en,
  input  logic  wt_en,
  input  addr_t addr,
  input  word_t wdata,
  output word_t rd_q
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // rd_en and wt_en are mutually exclusive (read vs. write access), so the
  // priority order below never matters in practice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= mem[addr];
    end else if (wt_en) begin
      rd_q <= wdata;
    end
  end

endmodule

// File: rtl/shab90_4096x16_sram.sv
// ---------------------------------------------------------------------------
// shab90_4096x16_sram
// Behavioural model of a 4096-word x 16-bit single-port synchronous SRAM,
// drop-in for the SHAB90_4096X16X1CM16 macro plus a reset input. Used as the
// k-means sample buffer (points packed x[15:8], y[7:0]).
// Ports:
//   clk : rising-edge clock (macro pin CK)
//   rst : asynchronous active-high reset; clears the read register at once,
//         suppresses writes, leaves array contents untouched
//   bus : slave side of shab90_4096x16_sram_if (A, DI, WEB, OE, CS)
//   DO  : read data, registered, then tri-stated when OE=0
// Build option:
//   SRAM_WRITE_THROUGH_EN defined : a write also loads DI into the read
//                                   register, so DO shows the new word.
//   undefined (default, datasheet) : a write leaves the read register as is.
// ---------------------------------------------------------------------------
module shab90_4096x16_sram
  import sram_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  shab90_4096x16_sram_if.slave        bus,
  output wire  [DATA_W-1:0]           DO
);

  logic  we;
  logic  rd_en;
  logic  wt_en;
  word_t rd_q;

  // Gating the write with rst keeps an edge that lands while rst=1 from
  // modifying the array (the read register is already held by its async clear).
  assign we    = bus.CS & ~bus.WEB & ~rst;
  assign rd_en = bus.CS &  bus.WEB;

`ifdef SRAM_WRITE_THROUGH_EN
  assign wt_en = bus.CS & ~bus.WEB;
`else
  assign wt_en = 1'b0;
`endif

  sram_array u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .rd_en (rd_en),
    .wt_en (wt_en),
    .addr  (bus.A),
    .wdata (bus.DI),
    .rd_q  (rd_q)
  );

  assign DO = bus.OE ? rd_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_shab90_4096x16_sram.sv
// ---------------------------------------------------------------------------
// tb_shab90_4096x16_sram
// Directed bench for shab90_4096x16_sram. Inputs change on the falling edge,
// DO is sampled on the following falling edge (one rising edge later) or a
// short delay after an asynchronous change.
// ---------------------------------------------------------------------------
module tb_shab90_4096x16_sram;

  logic        clk;
  logic        rst;
  wire  [15:0] do_w;

  int n_vec = 0;
  int n_err = 0;

  shab90_4096x16_sram_if bus ();

  shab90_4096x16_sram dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .DO  (do_w)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_write(input logic [11:0] a, input logic [15:0] d);
    bus.CS  = 1'b1;
    bus.WEB = 1'b0;
    bus.A   = a;
    bus.DI  = d;
  endtask

  task automatic drive_read(input logic [11:0] a);
    bus.CS  = 1'b1;
    bus.WEB = 1'b1;
    bus.A   = a;
  endtask

  task automatic drive_idle();
    bus.CS  = 1'b0;
    bus.WEB = 1'b1;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: DO=%h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] stream_word(input logic [11:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    rst     = 1'b1;
    bus.CS  = 1'b0;
    bus.WEB = 1'b1;
    bus.OE  = 1'b1;
    bus.A   = '0;
    bus.DI  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_state", do_w, 16'h0000);
    rst = 1'b0;

    // Basic write/read at both address extremes
    drive_write(12'h000, 16'hA55A); tick();
    drive_write(12'hFFF, 16'h0F0F); tick();
    drive_read(12'h000);            tick();
    check("rd_000", do_w, 16'hA55A);
    drive_read(12'hFFF);            tick();
    check("rd_fff", do_w, 16'h0F0F);

    // Preload for the write-contention step, then put 1234 on DO
    drive_write(12'h005, 16'h2222); tick();
    drive_write(12'h030, 16'h1234); tick();
    drive_read(12'h030);            tick();
    check("rd_030", do_w, 16'h1234);

    // Asynchronous reset: DO clears without an edge
    drive_idle();
    #2 rst = 1'b1;
    #1 check("rst_async", do_w, 16'h0000);

    // Write attempt while in reset must be suppressed
    @(negedge clk);
    drive_write(12'h005, 16'h1111); tick();
    check("rst_hold", do_w, 16'h0000);
    rst = 1'b0;
    drive_read(12'h005);            tick();
    check("rst_wr_blocked", do_w, 16'h2222);

    // Streaming writes, then back-to-back reads with no bubbles
    for (int i = 0; i < 4096; i++) begin
      drive_write(12'(i), stream_word(12'(i)));
      tick();
    end
    drive_read(12'h000);
    tick();
    for (int i = 0; i < 4096; i++) begin
      check("stream_rd", do_w, stream_word(12'(i)));
      if (i < 4095) drive_read(12'(i + 1));
      tick();
    end

    // CS idle holds DO, ignores A/DI/WEB; OE tri-states DO
    drive_write(12'h010, 16'hBEEF); tick();
    drive_read(12'h010);            tick();
    check("cs_rd_010", do_w, 16'hBEEF);
    bus.CS  = 1'b0;
    bus.A   = 12'h020;
    bus.WEB = 1'b0;
    bus.DI  = 16'h5555;
    tick();
    check("cs_idle_1", do_w, 16'hBEEF);
    tick();
    check("cs_idle_2", do_w, 16'hBEEF);
    bus.WEB = 1'b1;
    bus.OE  = 1'b0;
    #1;
    n_vec++;
    assert (do_w === 16'hzzzz) else begin
      n_err++;
      $error("FAIL oe_off: DO=%h expected zzzz", do_w);
    end
    bus.OE = 1'b1;
    #1 check("oe_on", do_w, 16'hBEEF);
    @(negedge clk);
    drive_read(12'h020);            tick();
    check("idle_no_write", do_w, stream_word(12'h020));

    // Write-through behaviour and read-after-write
    drive_write(12'h007, 16'h0001); tick();
    drive_read(12'h007);            tick();
    check("wt_pre", do_w, 16'h0001);
    drive_write(12'h007, 16'hCAFE); tick();
`ifdef SRAM_WRITE_THROUGH_EN
    check("wt_write", do_w, 16'hCAFE);
`else
    check("wt_write", do_w, 16'h0001);
`endif
    drive_read(12'h007);            tick();
    check("raw_007", do_w, 16'hCAFE);

    drive_idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
